// File: rtl/lsu_load_response_collector_pkg.sv
// Shared definitions for the LSU load response collector: sizes, FSM encoding
// and the dword-count clamp applied to incoming load descriptors.
package lsu_load_response_collector_pkg;

    localparam int NUM_LANES   = 64;
    localparam int DATA_W      = 32;
    localparam int MAX_DWORDS  = 4;
    localparam int VREG_ADDR_W = 10;
    localparam int WFID_W      = 6;
    localparam int LANE_W      = $clog2(NUM_LANES);
    localparam int NUM_W       = 3;

    localparam logic [NUM_W-1:0] MAX_NUM = NUM_W'(MAX_DWORDS);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COLLECT   = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_DONE      = 2'd3
    } lsu_state_t;

    // A zero count still loads one dword; anything above x4 saturates to x4.
    function automatic logic [NUM_W-1:0] clamp_num_dwords(input logic [NUM_W-1:0] raw);
        if (raw == '0) begin
            return NUM_W'(1);
        end else if (raw > MAX_NUM) begin
            return MAX_NUM;
        end else begin
            return raw;
        end
    endfunction

endpackage

// File: rtl/lsu_load_response_collector_if.sv
// Issue, memory response, VGPR write and completion signals of the collector.
// master = the surrounding LSU/memory/VGPR side, slave = the collector.
interface lsu_load_response_collector_if;
    import lsu_load_response_collector_pkg::*;

    logic                          issue_valid;
    logic                          issue_ready;
    logic [WFID_W-1:0]             issue_wfid;
    logic [VREG_ADDR_W-1:0]        issue_dest_vreg;
    logic [NUM_W-1:0]              issue_num_dwords;
    logic [NUM_LANES-1:0]          issue_exec;

    logic                          mem_rsp_valid;
    logic                          mem_rsp_ready;
    logic [DATA_W-1:0]             mem_rsp_data;

    logic                          vgpr_wr_en;
    logic                          vgpr_wr_ready;
    logic [VREG_ADDR_W-1:0]        vgpr_wr_addr;
    logic [NUM_LANES*DATA_W-1:0]   vgpr_wr_data;
    logic [NUM_LANES-1:0]          vgpr_wr_mask;

    logic                          done_valid;
    logic [WFID_W-1:0]             done_wfid;

    modport master (
        output issue_valid, issue_wfid, issue_dest_vreg, issue_num_dwords, issue_exec,
        output mem_rsp_valid, mem_rsp_data, vgpr_wr_ready,
        input  issue_ready, mem_rsp_ready,
        input  vgpr_wr_en, vgpr_wr_addr, vgpr_wr_data, vgpr_wr_mask,
        input  done_valid, done_wfid
    );

    modport slave (
        input  issue_valid, issue_wfid, issue_dest_vreg, issue_num_dwords, issue_exec,
        input  mem_rsp_valid, mem_rsp_data, vgpr_wr_ready,
        output issue_ready, mem_rsp_ready,
        output vgpr_wr_en, vgpr_wr_addr, vgpr_wr_data, vgpr_wr_mask,
        output done_valid, done_wfid
    );

endinterface

// File: rtl/lsu_load_response_collector_next_lane_finder.sv
// Priority encoder: next active lane strictly above ptr (or the lowest active
// lane when first), plus whether that lane is the highest active one.
module lsu_next_lane_finder
    import lsu_load_response_collector_pkg::*;
(
    input  logic [NUM_LANES-1:0] exec,
    input  logic [LANE_W-1:0]    ptr,
    input  logic                 first,
    output logic [LANE_W-1:0]    next_lane,
    output logic                 last
);

    logic [NUM_LANES-1:0] above_ptr_mask;
    logic [NUM_LANES-1:0] above_next_mask;
    logic [NUM_LANES-1:0] search;

    // (2<<p)-1 covers lanes 0..p; at p=63 the shift wraps to 0 and the mask becomes all ones.
    assign above_ptr_mask  = ~((NUM_LANES'(2) << ptr) - NUM_LANES'(1));
    assign search          = first ? exec : (exec & above_ptr_mask);

    always_comb begin
        next_lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (search[i]) begin
                next_lane = LANE_W'(i);
            end
        end
    end

    assign above_next_mask = ~((NUM_LANES'(2) << next_lane) - NUM_LANES'(1));
    assign last            = ~|(exec & above_next_mask);

endmodule

// File: rtl/lsu_load_response_collector.sv
// Collects per-lane load response beats into 64-lane rows, writes one VGPR row
// per dword, then pulses completion for the wavefront. One load in flight.
module lsu_load_response_collector
    import lsu_load_response_collector_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    lsu_load_response_collector_if.slave  bus
);

    lsu_state_t             state_reg, state_next;
    logic [WFID_W-1:0]      wfid_reg;
    logic [VREG_ADDR_W-1:0] dest_reg;
    logic [NUM_W-1:0]       num_reg;
    logic [NUM_W-1:0]       k_reg;
    logic [NUM_LANES-1:0]   exec_reg;
    logic [LANE_W-1:0]      ptr_reg;
    logic                   ptr_last_reg;
    logic [DATA_W-1:0]      row_reg [NUM_LANES];

    logic                        issue_ready, mem_rsp_ready, vgpr_wr_en, done_valid;
    logic                        issue_fire, beat_fire, wr_fire, last_dword, enter_collect;
    logic [NUM_LANES-1:0]        finder_exec;
    logic                        finder_first;
    logic [LANE_W-1:0]           finder_next;
    logic                        finder_last;
    logic [NUM_LANES*DATA_W-1:0] row_flat;

    assign issue_fire    = bus.issue_valid && (state_reg == ST_IDLE || state_reg == ST_DONE);
    assign beat_fire     = bus.mem_rsp_valid && (state_reg == ST_COLLECT);
    assign wr_fire       = bus.vgpr_wr_ready && (state_reg == ST_WRITEBACK);
    assign last_dword    = (k_reg == num_reg - NUM_W'(1));
    assign enter_collect = (state_next == ST_COLLECT) && (state_reg != ST_COLLECT);

    // Before a row starts, search the mask that will be in force: the incoming
    // descriptor when accepting an issue, the latched mask otherwise.
    assign finder_exec  = (state_reg == ST_IDLE || state_reg == ST_DONE) ? bus.issue_exec : exec_reg;
    assign finder_first = (state_reg != ST_COLLECT);

    lsu_next_lane_finder u_next_lane_finder (
        .exec      (finder_exec),
        .ptr       (ptr_reg),
        .first     (finder_first),
        .next_lane (finder_next),
        .last      (finder_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        issue_ready   = 1'b0;
        mem_rsp_ready = 1'b0;
        vgpr_wr_en    = 1'b0;
        done_valid    = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                issue_ready = 1'b1;
                done_valid  = (state_reg == ST_DONE);
                if (issue_fire) begin
                    state_next = (|bus.issue_exec) ? ST_COLLECT : ST_DONE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                mem_rsp_ready = 1'b1;
                if (beat_fire && ptr_last_reg) begin
                    state_next = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                vgpr_wr_en = 1'b1;
                if (wr_fire) begin
                    state_next = last_dword ? ST_DONE : ST_COLLECT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wfid_reg     <= '0;
            dest_reg     <= '0;
            num_reg      <= '0;
            k_reg        <= '0;
            exec_reg     <= '0;
            ptr_reg      <= '0;
            ptr_last_reg <= 1'b0;
        end else begin
            if (issue_fire) begin
                wfid_reg <= bus.issue_wfid;
                dest_reg <= bus.issue_dest_vreg;
                num_reg  <= clamp_num_dwords(bus.issue_num_dwords);
                exec_reg <= bus.issue_exec;
                k_reg    <= '0;
            end else if (wr_fire && !last_dword) begin
                k_reg <= k_reg + NUM_W'(1);
            end
            if (enter_collect || beat_fire) begin
                ptr_reg      <= finder_next;
                ptr_last_reg <= finder_last;
            end
        end
    end

    // Each row is wiped when collection of a dword begins, so inactive lanes read 0.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (!rst) begin
                    row_reg[gi] <= '0;
                end else if (enter_collect) begin
                    row_reg[gi] <= '0;
                end else if (beat_fire && ptr_reg == LANE_W'(gi)) begin
                    row_reg[gi] <= bus.mem_rsp_data;
                end
            end
        end
    endgenerate

    always_comb begin
        row_flat = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            row_flat[i*DATA_W +: DATA_W] = row_reg[i];
        end
    end

    assign bus.issue_ready   = issue_ready;
    assign bus.mem_rsp_ready = mem_rsp_ready;
    assign bus.vgpr_wr_en    = vgpr_wr_en;
    assign bus.vgpr_wr_addr  = dest_reg + VREG_ADDR_W'(k_reg);
    assign bus.vgpr_wr_data  = row_flat;
    assign bus.vgpr_wr_mask  = exec_reg;
    assign bus.done_valid    = done_valid;
    assign bus.done_wfid     = wfid_reg;

endmodule

// File: tb/tb_lsu_load_response_collector.sv
// Table-driven bench for the load response collector: a scoreboard of expected
// VGPR writes and completions, checked by a negedge monitor.
module tb_lsu_load_response_collector;
    import lsu_load_response_collector_pkg::*;

    localparam int BOUND = 400;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lsu_load_response_collector_if bus ();

    lsu_load_response_collector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [5:0]  wfid;
        logic [9:0]  dest;
        logic [2:0]  num_raw;
        logic [63:0] exec;
        bit          incr_data;
        bit          gaps;
        int          stall;
        int          exp_num;
        logic [9:0]  exp_last_addr;
    } vec_t;

    typedef struct {
        logic [9:0]    addr;
        logic [63:0]   mask;
        logic [2047:0] data;
    } wr_exp_t;

    typedef struct {
        logic [5:0] wfid;
        bit         zero;
    } done_exp_t;

    wr_exp_t   wr_q[$];
    done_exp_t done_q[$];
    vec_t      vecs[9];
    logic [31:0] beat_mem [4][64];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int issue_cyc = 0;
    int last_hs_cyc = -10;
    int seen_rsp_ready = 0;
    int seen_wr_en = 0;
    int n_writes_seen = 0;
    logic [9:0] last_wr_addr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_row(input string name, input logic [2047:0] act, input logic [2047:0] exp);
        int bad;
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            bad = 0;
            for (int i = 63; i >= 0; i--) begin
                if (act[i*32 +: 32] !== exp[i*32 +: 32]) bad = i;
            end
            $display("FAIL %s: lane %0d got 0x%08h, expected 0x%08h", name, bad,
                     act[bad*32 +: 32], exp[bad*32 +: 32]);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_issue_ready"}, 64'(bus.issue_ready), 64'd1);
        chk({tag, "_mem_rsp_ready"}, 64'(bus.mem_rsp_ready), 64'd0);
        chk({tag, "_vgpr_wr_en"}, 64'(bus.vgpr_wr_en), 64'd0);
        chk({tag, "_done_valid"}, 64'(bus.done_valid), 64'd0);
        chk({tag, "_addr"}, 64'(bus.vgpr_wr_addr), 64'd0);
        chk({tag, "_mask"}, bus.vgpr_wr_mask, 64'd0);
        chk({tag, "_done_wfid"}, 64'(bus.done_wfid), 64'd0);
        chk_row({tag, "_data"}, bus.vgpr_wr_data, '0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops the scoreboard on each write handshake and each completion.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (bus.mem_rsp_ready) seen_rsp_ready++;
            if (bus.vgpr_wr_en) seen_wr_en++;
            if (bus.vgpr_wr_en && bus.vgpr_wr_ready) begin
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h written, none expected", bus.vgpr_wr_addr);
                end else begin
                    wr_exp_t e;
                    e = wr_q.pop_front();
                    chk("wr_addr", 64'(bus.vgpr_wr_addr), 64'(e.addr));
                    chk("wr_mask", bus.vgpr_wr_mask, e.mask);
                    chk_row("wr_data", bus.vgpr_wr_data, e.data);
                    $display("write addr=0x%03h mask=0x%016h cycle=%0d", bus.vgpr_wr_addr, bus.vgpr_wr_mask, cyc);
                end
                last_hs_cyc = cyc;
                last_wr_addr = bus.vgpr_wr_addr;
                n_writes_seen++;
            end
            if (bus.done_valid) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: wfid %0d completed, none expected", bus.done_wfid);
                end else begin
                    done_exp_t d;
                    d = done_q.pop_front();
                    chk("done_wfid", 64'(bus.done_wfid), 64'(d.wfid));
                    chk("done_latency", 64'(cyc), d.zero ? 64'(issue_cyc + 1) : 64'(last_hs_cyc + 1));
                    $display("done wfid=%0d cycle=%0d", bus.done_wfid, cyc);
                end
            end
        end
    end

    function automatic int highest_lane(input logic [63:0] m);
        int h;
        h = -1;
        for (int i = 0; i < 64; i++) if (m[i]) h = i;
        return h;
    endfunction

    task automatic drive_beats(input vec_t v);
        int cnt;
        int hi;
        int n;
        hi = highest_lane(v.exec);
        n = (v.exec != 0) ? v.exp_num : 0;
        for (int k = 0; k < n; k++) begin
            for (int l = 0; l < 64; l++) begin
                if (v.exec[l]) begin
                    if (v.gaps) begin
                        repeat ($urandom_range(0, 2)) begin
                            bus.mem_rsp_valid = 1'b0;
                            bus.mem_rsp_data = $urandom;
                            @(posedge clk); #1;
                        end
                    end
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data = beat_mem[k][l];
                    cnt = 0;
                    @(negedge clk);
                    while (!bus.mem_rsp_ready && cnt < BOUND) begin
                        @(negedge clk);
                        cnt++;
                    end
                    if (cnt >= BOUND) begin
                        chk("beat_accept_timeout", 64'(bus.mem_rsp_ready), 64'd1);
                        bus.mem_rsp_valid = 1'b0;
                        return;
                    end
                    @(posedge clk); #1;
                    if (l == hi) begin
                        bus.mem_rsp_valid = 1'b0;
                        bus.mem_rsp_data = $urandom;
                        @(negedge clk);
                        chk("wr_en_latency", 64'(bus.vgpr_wr_en), 64'd1);
                        @(posedge clk); #1;
                    end
                end
            end
        end
        bus.mem_rsp_valid = 1'b0;
    endtask

    task automatic drive_wr_ready(input vec_t v);
        int cnt;
        if (v.stall == 0 || v.exec == 0) return;
        bus.vgpr_wr_ready = 1'b0;
        for (int k = 0; k < v.exp_num; k++) begin
            cnt = 0;
            @(negedge clk);
            while (!bus.vgpr_wr_en && cnt < BOUND) begin
                @(negedge clk);
                cnt++;
            end
            chk("stall_wr_en_seen", 64'(bus.vgpr_wr_en), 64'd1);
            for (int s = 0; s < v.stall; s++) begin
                if (wr_q.size() > 0) begin
                    chk("stall_addr", 64'(bus.vgpr_wr_addr), 64'(wr_q[0].addr));
                    chk("stall_mask", bus.vgpr_wr_mask, wr_q[0].mask);
                    chk_row("stall_data", bus.vgpr_wr_data, wr_q[0].data);
                end
                chk("stall_wr_en", 64'(bus.vgpr_wr_en), 64'd1);
                chk("stall_no_beat", 64'(bus.mem_rsp_ready), 64'd0);
                @(negedge clk);
            end
            @(posedge clk); #1;
            bus.vgpr_wr_ready = 1'b1;
            @(posedge clk); #1;
            bus.vgpr_wr_ready = 1'b0;
        end
        bus.vgpr_wr_ready = 1'b1;
    endtask

    task automatic run_load(input vec_t v);
        wr_exp_t   e;
        done_exp_t d;
        int cnt;
        int n_wr;
        int writes_before;
        writes_before = n_writes_seen;
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 64; l++) begin
                beat_mem[k][l] = v.incr_data ? (32'h100 + 32'(l) + 32'h1000 * 32'(k)) : $urandom;
            end
        end
        n_wr = (v.exec != 0) ? v.exp_num : 0;
        for (int k = 0; k < n_wr; k++) begin
            e.addr = v.dest + 10'(k);
            e.mask = v.exec;
            e.data = '0;
            for (int l = 0; l < 64; l++) begin
                if (v.exec[l]) e.data[l*32 +: 32] = beat_mem[k][l];
            end
            wr_q.push_back(e);
        end
        d.wfid = v.wfid;
        d.zero = (v.exec == 0);
        done_q.push_back(d);

        bus.issue_valid = 1'b1;
        bus.issue_wfid = v.wfid;
        bus.issue_dest_vreg = v.dest;
        bus.issue_num_dwords = v.num_raw;
        bus.issue_exec = v.exec;
        cnt = 0;
        @(negedge clk);
        while (!bus.issue_ready && cnt < BOUND) begin
            @(negedge clk);
            cnt++;
        end
        chk("issue_ready", 64'(bus.issue_ready), 64'd1);
        issue_cyc = cyc;
        @(posedge clk); #1;
        bus.issue_valid = 1'b0;
        bus.issue_exec = $urandom;
        @(negedge clk);
        chk("rsp_ready_after_issue", 64'(bus.mem_rsp_ready), (v.exec != 0) ? 64'd1 : 64'd0);
        @(posedge clk); #1;

        fork
            drive_beats(v);
            drive_wr_ready(v);
        join

        cnt = 0;
        while (done_q.size() != 0 && cnt < BOUND) begin
            @(negedge clk);
            cnt++;
        end
        chk("done_seen", 64'(done_q.size()), 64'd0);
        chk("write_count", 64'(n_writes_seen - writes_before), 64'(n_wr));
        if (n_wr != 0) chk("last_addr", 64'(last_wr_addr), 64'(v.exp_last_addr));
        wr_q.delete();
        done_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rsp_before;
        int en_before;
        int cnt;

        vecs[0] = '{6'd1,  10'h010, 3'd1, {64{1'b1}},              1'b1, 1'b0, 0, 1, 10'h010};
        vecs[1] = '{6'd2,  10'h3FF, 3'd2, 64'h5,                   1'b0, 1'b0, 0, 2, 10'h000};
        vecs[2] = '{6'd7,  10'h055, 3'd1, 64'h0,                   1'b0, 1'b0, 0, 1, 10'h055};
        vecs[3] = '{6'd12, 10'h200, 3'd3, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 5, 3, 10'h202};
        vecs[4] = '{6'd33, 10'h0AB, 3'd1, 64'hF0F0,                1'b0, 1'b1, 0, 1, 10'h0AB};
        vecs[5] = '{6'd40, 10'h3FD, 3'd0, 64'h8000_0000_0000_0001, 1'b0, 1'b0, 0, 1, 10'h3FD};
        vecs[6] = '{6'd63, 10'h3FE, 3'd7, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 0, 4, 10'h001};
        vecs[7] = '{6'd21, 10'h100, 3'd4, {64{1'b1}},              1'b0, 1'b1, 2, 4, 10'h103};
        vecs[8] = '{6'd0,  10'h000, 3'd5, 64'h0,                   1'b0, 1'b0, 0, 4, 10'h000};

        bus.issue_valid = 1'b0;
        bus.issue_wfid = '0;
        bus.issue_dest_vreg = '0;
        bus.issue_num_dwords = '0;
        bus.issue_exec = '0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data = '0;
        bus.vgpr_wr_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        $display("reset state checked");
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            rsp_before = seen_rsp_ready;
            en_before = seen_wr_en;
            run_load(vecs[i]);
            if (vecs[i].exec == 0) begin
                chk("exec0_no_rsp_ready", 64'(seen_rsp_ready - rsp_before), 64'd0);
                chk("exec0_no_wr_en", 64'(seen_wr_en - en_before), 64'd0);
            end
            $display("load %0d wfid=%0d exec=0x%016h num=%0d done", i, vecs[i].wfid, vecs[i].exec, vecs[i].num_raw);
        end

        // Reset in the middle of collecting a row: nothing may complete or be written.
        bus.issue_valid = 1'b1;
        bus.issue_wfid = 6'd9;
        bus.issue_dest_vreg = 10'h050;
        bus.issue_num_dwords = 3'd2;
        bus.issue_exec = {64{1'b1}};
        @(negedge clk);
        chk("mid_reset_issue_ready", 64'(bus.issue_ready), 64'd1);
        @(posedge clk); #1;
        bus.issue_valid = 1'b0;
        for (int l = 0; l < 10; l++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data = $urandom;
            cnt = 0;
            @(negedge clk);
            while (!bus.mem_rsp_ready && cnt < BOUND) begin
                @(negedge clk);
                cnt++;
            end
            @(posedge clk); #1;
        end
        chk_row("pre_reset_partial_row_nonzero_lane9", 2048'(|bus.vgpr_wr_data[9*32 +: 32]), 2048'd1);
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_reset_outputs("mid_reset");
        $display("mid-operation reset checked");
        @(posedge clk); #1;
        rst = 1'b1;
        run_load('{6'd9, 10'h123, 3'd2, 64'h00FF_0000_0000_00F1, 1'b0, 1'b0, 0, 2, 10'h124});
        $display("post-reset load done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
